// File: rtl/bram_read_arbiter_pkg.sv
// bram_read_arbiter_pkg: FSM state encoding and one-hot decode helper shared by the arbiter files
package bram_read_arbiter_pkg;
    localparam logic ST_ARB    = 1'b0;
    localparam logic ST_LOCKED = 1'b1;
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < 8; k++) idx |= oh[k] ? 3'(k) : 3'd0;
        return idx;
    endfunction
endpackage

// File: rtl/bram_read_arbiter_rr_pick.sv
// bram_read_arbiter_rr_pick: round-robin pick by rotating requests to start at ptr, taking the lowest set bit, rotating back
module bram_read_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win,
    output logic          o_valid
);
    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;
    always_comb begin
        w_rot   = N'({i_req, i_req} >> i_ptr);
        w_first = w_rot & (~w_rot + N'(1));
        o_win   = N'(({w_first, w_first} << i_ptr) >> N);
        o_valid = |i_req;
    end
endmodule

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin sharing of one BRAM read port with optional per-requester lock and tagged read return
module bram_read_arbiter
    import bram_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk_p,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_dout
);
    localparam int PW = $clog2(NUM_REQ);
    logic               r_state;
    logic               w_next_state;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      w_idx;
    logic [PW-1:0]      w_ptr_inc;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_win;
    logic               w_any;
    logic [NUM_REQ-1:0] r_tag [RD_LATENCY];

    // a locked owner that drops req releases the port, so everyone arbitrates that same cycle
    always_comb begin
        w_elig    = (r_state == ST_LOCKED && req[r_owner]) ? (req & (NUM_REQ'(1) << r_owner)) : req;
        w_idx     = PW'(onehot2idx(8'(w_win)));
        w_ptr_inc = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + PW'(1);
    end

    bram_read_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .i_req  (w_elig),
        .i_ptr  (r_ptr),
        .o_win  (w_win),
        .o_valid(w_any)
    );

    always_ff @(posedge clk_p) begin
        if (rst) begin
            r_state <= ST_ARB;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_any) begin
                r_owner <= w_idx;
                r_ptr   <= w_ptr_inc;
            end
        end
    end

    always_comb begin
        w_next_state = (w_any && req_lock[w_idx]) ? ST_LOCKED : ST_ARB;
    end

    always_comb begin
        gnt       = rst ? '0 : w_win;
        bram_en   = w_any & ~rst;
        bram_addr = bram_en ? req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        rd_valid  = rst ? '0 : r_tag[RD_LATENCY-1];
        rd_data   = bram_dout;
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= gnt;
            for (int k = 1; k < RD_LATENCY; k++) r_tag[k] <= r_tag[k-1];
        end
    end
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: drives latency-1 and latency-3 arbiters in parallel against a round-robin/lock reference model
module tb_bram_read_arbiter;
    localparam int N  = 2;
    localparam int AW = 19;
    localparam int DW = 12;

    logic            clk_p = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    gnt [2];
    logic [N-1:0]    rdv [2];
    logic [DW-1:0]   rdd [2];
    logic            en [2];
    logic [AW-1:0]   baddr [2];
    logic [DW-1:0]   dout1;
    logic [DW-1:0]   p3 [3];

    always #5 clk_p = ~clk_p;

    bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
        .clk_p(clk_p), .rst(rst), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt[0]), .rd_valid(rdv[0]), .rd_data(rdd[0]), .bram_en(en[0]),
        .bram_addr(baddr[0]), .bram_dout(dout1)
    );

    bram_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
        .clk_p(clk_p), .rst(rst), .req(req), .req_addr(req_addr), .req_lock(req_lock),
        .gnt(gnt[1]), .rd_valid(rdv[1]), .rd_data(rdd[1]), .bram_en(en[1]),
        .bram_addr(baddr[1]), .bram_dout(p3[2])
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return DW'(32'(a) * 7 + 32'(a >> 5) + 3);
    endfunction

    // BRAM models with read latency 1 and 3
    always @(posedge clk_p) begin
        dout1 <= pix(baddr[0]);
        p3[0] <= pix(baddr[1]);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    typedef struct {
        int            due;
        logic [N-1:0]  v;
        logic [DW-1:0] d;
    } rd_t;

    rd_t          q1[$];
    rd_t          q3[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           m_ptr = 0;
    int           m_owner = 0;
    bit           m_locked = 0;
    logic [N-1:0] m_gnt = '0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, act, exp);
        end
    endtask

    // monitor: reference model of arbitration and read return, compared every cycle
    always @(negedge clk_p) begin
        logic [N-1:0]  ev [2];
        logic [DW-1:0] ed [2];
        logic [AW-1:0] ea;
        int            w;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("rst_gnt", k, 32'(gnt[k]), 0);
                chk("rst_rd_valid", k, 32'(rdv[k]), 0);
                chk("rst_bram_en", k, 32'(en[k]), 0);
                chk("rst_bram_addr", k, 32'(baddr[k]), 0);
            end
            q1.delete();
            q3.delete();
            m_ptr = 0;
            m_owner = 0;
            m_locked = 0;
            m_gnt = '0;
        end else begin
            ev[0] = '0; ev[1] = '0; ed[0] = '0; ed[1] = '0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                ev[0] = q1[0].v; ed[0] = q1[0].d; void'(q1.pop_front());
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                ev[1] = q3[0].v; ed[1] = q3[0].d; void'(q3.pop_front());
            end
            for (int k = 0; k < 2; k++) begin
                chk("rd_valid", k, 32'(rdv[k]), 32'(ev[k]));
                if (ev[k] != '0) chk("rd_data", k, 32'(rdd[k]), 32'(ed[k]));
            end
            w = -1;
            if (m_locked && !req[m_owner]) m_locked = 0;
            if (m_locked) begin
                w = m_owner;
                if (!req_lock[w]) begin
                    m_locked = 0;
                    m_ptr = (w + 1) % N;
                end
            end else begin
                for (int j = 0; j < N; j++) if (w < 0 && req[(m_ptr + j) % N]) w = (m_ptr + j) % N;
                if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                    if (req_lock[w]) begin
                        m_locked = 1;
                        m_owner = w;
                    end
                end
            end
            m_gnt = (w >= 0) ? N'(1) << w : '0;
            ea = (w >= 0) ? req_addr[w*AW +: AW] : '0;
            for (int k = 0; k < 2; k++) begin
                chk("gnt", k, 32'(gnt[k]), 32'(m_gnt));
                chk("bram_en", k, 32'(en[k]), 32'(w >= 0));
                chk("bram_addr", k, 32'(baddr[k]), 32'(ea));
            end
            if (w >= 0) begin
                q1.push_back('{cyc + 1, m_gnt, pix(ea)});
                q3.push_back('{cyc + 3, m_gnt, pix(ea)});
            end
        end
        cyc++;
    end

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst = r;
        req = rq;
        req_lock = lk;
        req_addr = {a1, a0};
        @(posedge clk_p);
        #1;
    endtask

    initial begin
        logic [N-1:0]  pend;
        logic [N-1:0]  plk;
        logic [AW-1:0] pa [N];
        logic          r;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 2'b01, 0, AW'(301 + i), 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 2'b11, 0, AW'(1000 + i), AW'(2000 + i));
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        begin
            logic [AW-1:0] la [8];
            la = '{0, 1, 2, 300, 302, 600, 601, 602};
            drive(0, 2'b10, 2'b10, 77, la[0]);
            for (int i = 1; i < 8; i++) drive(0, 2'b11, 2'b10, 77, la[i]);
        end
        drive(0, 2'b11, 0, 77, 700);
        drive(0, 2'b01, 0, 77, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        drive(0, 2'b10, 2'b10, 0, 900);
        drive(0, 2'b11, 2'b10, 55, 901);
        drive(0, 2'b01, 0, 55, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 2'b11, 0, AW'(40 + i), AW'(80 + i));
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        drive(0, 2'b10, 0, 0, 11);
        drive(0, 2'b11, 0, 12, 13);
        drive(0, 2'b11, 0, 14, 15);
        drive(1, 2'b11, 0, 16, 17);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        drive(0, 2'b11, 0, 18, 19);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);
        pend = '0;
        plk = '0;
        for (int i = 0; i < N; i++) pa[i] = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(9) < 6) begin
                    pend[i] = 1'b1;
                    pa[i] = AW'($urandom);
                    plk[i] = ($urandom_range(9) < 3);
                end
            end
            r = ($urandom_range(199) == 0);
            drive(r, pend, plk, pa[0], pa[1]);
            pend = r ? '0 : (pend & ~m_gnt);
        end
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
